// File: rtl/matrix_row_feeder_pkg.sv
// Shared definitions for the matrix row feeder: state encoding and default sizing.
package matrix_row_feeder_pkg;

  localparam int ELEMENT_WIDTH_DEF = 32;
  localparam int NM_DEF            = 4;
  localparam int NI_DEF            = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    PRESENT = 2'd3
  } feederState_e;

  // Lane indices need at least one bit even for a single-lane build.
  function automatic int laneWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/feeder_addr_gen.sv
// Address generator for the row feeder: maps (group, chunk, lane) to memory addresses.
module feeder_addr_gen
  import matrix_row_feeder_pkg::*;
#(
  parameter int NM     = NM_DEF,
  parameter int LANE_W = laneWidth(NM)
) (
  input  logic [31:0]       group_i,
  input  logic [31:0]       chunk_i,
  input  logic [31:0]       chunksPerRow_i,
  input  logic [LANE_W-1:0] lane_i,
  output logic [31:0]       matAddr_o,
  output logic [31:0]       vecAddr_o
);

  localparam logic [31:0] NM_32 = 32'(NM);

  logic [31:0] rowIdx;

  // Lane k carries row g*NM+k; lanes are issued from NM-1 downwards, so the
  // address stream descends within a group. All arithmetic wraps at 32 bits.
  always_comb begin
    rowIdx    = group_i * NM_32 + 32'(lane_i);
    matAddr_o = rowIdx * chunksPerRow_i + chunk_i;
    vecAddr_o = chunk_i;
  end

endmodule

// File: rtl/matrix_row_feeder.sv
// Fetches NM matrix-row chunks and the matching vector chunk per step and hands each
// lane its chunk through a you_can_read / I_am_ready handshake.
module matrix_row_feeder
  import matrix_row_feeder_pkg::*;
#(
  parameter int element_width               = ELEMENT_WIDTH_DEF,
  parameter int no_of_row_by_vector_modules = NM_DEF,
  parameter int NI                          = NI_DEF
) (
  input  logic                                                    clk,
  input  logic                                                    reset,
  input  logic                                                    start,
  input  logic                                                    memories_pre_preprocess,
  input  logic [31:0]                                             total_with_additional_A,
  input  logic [31:0]                                             chunks_per_row,
  output logic [31:0]                                             mem_a_addr,
  output logic                                                    mem_a_rd_en,
  input  logic [NI*element_width-1:0]                             mem_a_rd_data,
  output logic [31:0]                                             mem_v_addr,
  output logic                                                    mem_v_rd_en,
  input  logic [NI*element_width-1:0]                             mem_v_rd_data,
  output logic [no_of_row_by_vector_modules*NI*element_width-1:0] A_rows,
  output logic [no_of_row_by_vector_modules*NI*element_width-1:0] vector_rows,
  output logic [no_of_row_by_vector_modules-1:0]                  you_can_read,
  input  logic [no_of_row_by_vector_modules-1:0]                  I_am_ready,
  output logic                                                    busy,
  output logic                                                    feed_done
);

  localparam int                NM       = no_of_row_by_vector_modules;
  localparam int                CW       = NI * element_width;
  localparam int                LANE_W   = laneWidth(NM);
  localparam logic [LANE_W-1:0] TOP_LANE = LANE_W'(NM - 1);
  localparam logic [31:0]       NM_32    = 32'(NM);

  feederState_e      state_q, state_d;
  logic [31:0]       group_q, group_d;
  logic [31:0]       chunk_q, chunk_d;
  logic [LANE_W-1:0] issueIdx_q, issueIdx_d;
  logic              pending_q, pending_d;
  logic [NM-1:0]     youCanRead_q, youCanRead_d;
  logic              capValid_q, capValid_d;
  logic              capVec_q, capVec_d;
  logic [LANE_W-1:0] capLane_q, capLane_d;
  logic [NM*CW-1:0]  aRows_q, vecRows_q;

  logic [31:0]       groupCount, chunkCount, matAddr, vecAddr;
  logic [LANE_W-1:0] issueLane;
  logic [NM-1:0]     remaining;

  assign groupCount = total_with_additional_A / NM_32;
  assign chunkCount = (chunks_per_row == 32'd0) ? 32'd1 : chunks_per_row;
  assign issueLane  = TOP_LANE - issueIdx_q;
  assign remaining  = youCanRead_q & ~I_am_ready;

  feeder_addr_gen #(
    .NM     (NM),
    .LANE_W (LANE_W)
  ) u_addr_gen (
    .group_i        (group_q),
    .chunk_i        (chunk_q),
    .chunksPerRow_i (chunkCount),
    .lane_i         (issueLane),
    .matAddr_o      (matAddr),
    .vecAddr_o      (vecAddr)
  );

  assign mem_a_rd_en  = (state_q == ISSUE);
  assign mem_v_rd_en  = (state_q == ISSUE) && (issueIdx_q == '0);
  assign mem_a_addr   = mem_a_rd_en ? matAddr : 32'd0;
  assign mem_v_addr   = mem_v_rd_en ? vecAddr : 32'd0;
  assign A_rows       = aRows_q;
  assign vector_rows  = vecRows_q;
  assign you_can_read = youCanRead_q;
  assign busy         = (state_q != IDLE);
  assign feed_done    = (group_q == groupCount) && (groupCount != 32'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      group_q      <= 32'd0;
      chunk_q      <= 32'd0;
      issueIdx_q   <= '0;
      pending_q    <= 1'b0;
      youCanRead_q <= '0;
      capValid_q   <= 1'b0;
      capVec_q     <= 1'b0;
      capLane_q    <= '0;
    end else begin
      state_q      <= state_d;
      group_q      <= group_d;
      chunk_q      <= chunk_d;
      issueIdx_q   <= issueIdx_d;
      pending_q    <= pending_d;
      youCanRead_q <= youCanRead_d;
      capValid_q   <= capValid_d;
      capVec_q     <= capVec_d;
      capLane_q    <= capLane_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    group_d      = group_q;
    chunk_d      = chunk_q;
    issueIdx_d   = issueIdx_q;
    pending_d    = pending_q;
    youCanRead_d = youCanRead_q;
    capValid_d   = 1'b0;
    capVec_d     = 1'b0;
    capLane_d    = capLane_q;

    if (!start) begin
      state_d      = IDLE;
      group_d      = 32'd0;
      chunk_d      = 32'd0;
      issueIdx_d   = '0;
      pending_d    = 1'b0;
      youCanRead_d = '0;
    end else begin
      // A request seen while busy is remembered once; repeats collapse into it.
      if (memories_pre_preprocess && (state_q != IDLE)) begin
        pending_d = 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (memories_pre_preprocess || pending_q) begin
            pending_d = 1'b0;
            if (group_q < groupCount) begin
              state_d    = ISSUE;
              issueIdx_d = '0;
            end
          end
        end

        ISSUE: begin
          capValid_d = 1'b1;
          capLane_d  = issueLane;
          capVec_d   = mem_v_rd_en;
          if (issueIdx_q == TOP_LANE) begin
            state_d = CAPTURE;
          end else begin
            issueIdx_d = issueIdx_q + LANE_W'(1);
          end
        end

        CAPTURE: begin
          state_d      = PRESENT;
          youCanRead_d = '1;
        end

        PRESENT: begin
          youCanRead_d = remaining;
          if (remaining == '0) begin
            issueIdx_d = '0;
            if (chunk_q < chunkCount - 32'd1) begin
              chunk_d = chunk_q + 32'd1;
              state_d = ISSUE;
            end else begin
              chunk_d = 32'd0;
              group_d = group_q + 32'd1;
              state_d = IDLE;
            end
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  // Read data arrives one cycle after its strobe; the capture tags say where it goes.
  always_ff @(posedge clk) begin
    if (reset) begin
      aRows_q   <= '0;
      vecRows_q <= '0;
    end else if (capValid_q) begin
      aRows_q[int'(capLane_q)*CW +: CW] <= mem_a_rd_data;
      if (capVec_q) begin
        vecRows_q <= {NM{mem_v_rd_data}};
      end
    end
  end

endmodule

// File: tb/tb_matrix_row_feeder.sv
// Directed self-checking bench for matrix_row_feeder with a 1-cycle-latency memory model.
module tb_matrix_row_feeder;

  localparam int EW = 32;
  localparam int NM = 4;
  localparam int NI = 8;
  localparam int CW = NI * EW;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            start = 1'b0;
  logic            memories_pre_preprocess = 1'b0;
  logic [31:0]     total_with_additional_A = 32'd0;
  logic [31:0]     chunks_per_row = 32'd0;
  logic [31:0]     mem_a_addr, mem_v_addr;
  logic            mem_a_rd_en, mem_v_rd_en;
  logic [CW-1:0]   mem_a_rd_data = '0;
  logic [CW-1:0]   mem_v_rd_data = '0;
  logic [NM*CW-1:0] A_rows, vector_rows;
  logic [NM-1:0]   you_can_read;
  logic [NM-1:0]   I_am_ready = '0;
  logic            busy, feed_done;

  int          testsRun = 0;
  int          testsFailed = 0;
  logic [31:0] aLog[$];
  logic [31:0] vLog[$];

  matrix_row_feeder #(
    .element_width               (EW),
    .no_of_row_by_vector_modules (NM),
    .NI                          (NI)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .start                   (start),
    .memories_pre_preprocess (memories_pre_preprocess),
    .total_with_additional_A (total_with_additional_A),
    .chunks_per_row          (chunks_per_row),
    .mem_a_addr              (mem_a_addr),
    .mem_a_rd_en             (mem_a_rd_en),
    .mem_a_rd_data           (mem_a_rd_data),
    .mem_v_addr              (mem_v_addr),
    .mem_v_rd_en             (mem_v_rd_en),
    .mem_v_rd_data           (mem_v_rd_data),
    .A_rows                  (A_rows),
    .vector_rows             (vector_rows),
    .you_can_read            (you_can_read),
    .I_am_ready              (I_am_ready),
    .busy                    (busy),
    .feed_done               (feed_done)
  );

  always #5 clk = ~clk;

  function automatic logic [CW-1:0] aChunk(input logic [31:0] addr);
    logic [CW-1:0] r;
    for (int j = 0; j < NI; j++) r[j*EW +: EW] = 32'hA000_0000 | (addr << 8) | 32'(j);
    return r;
  endfunction

  function automatic logic [CW-1:0] vChunk(input logic [31:0] addr);
    logic [CW-1:0] r;
    for (int j = 0; j < NI; j++) r[j*EW +: EW] = 32'hB000_0000 | (addr << 8) | 32'(j);
    return r;
  endfunction

  function automatic logic [CW-1:0] laneOf(input logic [NM*CW-1:0] v, input int k);
    return v[k*CW +: CW];
  endfunction

  // Memory model plus a log of every strobed address.
  always @(posedge clk) begin
    if (mem_a_rd_en) begin
      mem_a_rd_data <= aChunk(mem_a_addr);
      aLog.push_back(mem_a_addr);
    end
    if (mem_v_rd_en) begin
      mem_v_rd_data <= vChunk(mem_v_addr);
      vLog.push_back(mem_v_addr);
    end
  end

  task automatic doReset();
    reset = 1'b1;
    start = 1'b1;
    memories_pre_preprocess = 1'b0;
    I_am_ready = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    aLog.delete();
    vLog.delete();
  endtask

  task automatic pulseRequest();
    memories_pre_preprocess = 1'b1;
    @(posedge clk);
    #1 memories_pre_preprocess = 1'b0;
  endtask

  task automatic handshakeAll();
    I_am_ready = 4'hF;
    @(posedge clk);
    #1 I_am_ready = '0;
  endtask

  task automatic waitAllReady(input int maxCycles, output bit timedOut);
    timedOut = 1'b1;
    for (int i = 0; i < maxCycles; i++) begin
      @(negedge clk);
      if (you_can_read === 4'hF) begin
        timedOut = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    total_with_additional_A = 32'd8;
    chunks_per_row = 32'd1;
    reset = 1'b1;
    start = 1'b1;
    memories_pre_preprocess = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    testsRun++; if (mem_a_addr !== 32'd0) begin testsFailed++; $display("[TB] FAIL reset_a_addr: got %0d want 0", mem_a_addr); end
    testsRun++; if (mem_a_rd_en !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_a_rd_en: got %b want 0", mem_a_rd_en); end
    testsRun++; if (mem_v_addr !== 32'd0) begin testsFailed++; $display("[TB] FAIL reset_v_addr: got %0d want 0", mem_v_addr); end
    testsRun++; if (mem_v_rd_en !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_v_rd_en: got %b want 0", mem_v_rd_en); end
    testsRun++; if (A_rows !== '0) begin testsFailed++; $display("[TB] FAIL reset_A_rows: nonzero, want 0"); end
    testsRun++; if (vector_rows !== '0) begin testsFailed++; $display("[TB] FAIL reset_vector_rows: nonzero, want 0"); end
    testsRun++; if (you_can_read !== 4'h0) begin testsFailed++; $display("[TB] FAIL reset_you_can_read: got %b want 0000", you_can_read); end
    testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    testsRun++; if (feed_done !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_feed_done: got %b want 0", feed_done); end
    #1 reset = 1'b0;
    memories_pre_preprocess = 1'b0;
    aLog.delete();
    vLog.delete();
  endtask

  task automatic test_single_group();
    logic [3:0] expYcr;
    doReset();
    total_with_additional_A = 32'd8;
    chunks_per_row = 32'd1;
    pulseRequest();
    for (int i = 0; i < NM; i++) begin
      @(negedge clk);
      testsRun++; if (mem_a_rd_en !== 1'b1 || mem_a_addr !== 32'(3 - i)) begin testsFailed++; $display("[TB] FAIL single_a_addr%0d: got en=%b addr=%0d want en=1 addr=%0d", i, mem_a_rd_en, mem_a_addr, 3 - i); end
      testsRun++; if (mem_v_rd_en !== (i == 0) || mem_v_addr !== 32'd0) begin testsFailed++; $display("[TB] FAIL single_v%0d: got en=%b addr=%0d want en=%b addr=0", i, mem_v_rd_en, mem_v_addr, (i == 0)); end
      @(posedge clk);
    end
    @(negedge clk);
    testsRun++; if (you_can_read !== 4'h0 || busy !== 1'b1 || mem_a_rd_en !== 1'b0) begin testsFailed++; $display("[TB] FAIL single_capture: got ycr=%b busy=%b en=%b want 0000/1/0", you_can_read, busy, mem_a_rd_en); end
    @(negedge clk);
    testsRun++; if (you_can_read !== 4'hF) begin testsFailed++; $display("[TB] FAIL single_ycr_E0p5: got %b want 1111", you_can_read); end
    for (int k = 0; k < NM; k++) begin
      testsRun++; if (laneOf(A_rows, k) !== aChunk(32'(k))) begin testsFailed++; $display("[TB] FAIL single_A_lane%0d: got %h want %h", k, laneOf(A_rows, k), aChunk(32'(k))); end
      testsRun++; if (laneOf(vector_rows, k) !== vChunk(32'd0)) begin testsFailed++; $display("[TB] FAIL single_V_lane%0d: got %h want %h", k, laneOf(vector_rows, k), vChunk(32'd0)); end
    end
    for (int i = 0; i < NM; i++) begin
      I_am_ready = 4'b0001 << i;
      @(posedge clk);
      #1 I_am_ready = '0;
      @(negedge clk);
      expYcr = 4'hF << (i + 1);
      testsRun++; if (you_can_read !== expYcr) begin testsFailed++; $display("[TB] FAIL hs_step%0d: got %b want %b", i, you_can_read, expYcr); end
      for (int j = i + 1; j < NM; j++) begin
        testsRun++; if (laneOf(A_rows, j) !== aChunk(32'(j))) begin testsFailed++; $display("[TB] FAIL hs_stable%0d_lane%0d: got %h want %h", i, j, laneOf(A_rows, j), aChunk(32'(j))); end
      end
    end
    testsRun++; if (busy !== 1'b0 || feed_done !== 1'b0) begin testsFailed++; $display("[TB] FAIL single_end: got busy=%b done=%b want 0/0", busy, feed_done); end
  endtask

  task automatic test_two_chunks();
    bit timedOut;
    logic [31:0] expA[8];
    expA = '{32'd6, 32'd4, 32'd2, 32'd0, 32'd7, 32'd5, 32'd3, 32'd1};
    doReset();
    total_with_additional_A = 32'd8;
    chunks_per_row = 32'd2;
    pulseRequest();
    waitAllReady(30, timedOut);
    testsRun++; if (timedOut) begin testsFailed++; $display("[TB] FAIL chunk0_wait: got timeout want ycr=1111"); end
    I_am_ready = 4'b0111;
    @(posedge clk);
    #1 I_am_ready = '0;
    @(negedge clk);
    testsRun++; if (you_can_read !== 4'b1000) begin testsFailed++; $display("[TB] FAIL chunk0_partial: got %b want 1000", you_can_read); end
    repeat (2) @(negedge clk);
    testsRun++; if (aLog.size() != 4 || mem_a_rd_en !== 1'b0) begin testsFailed++; $display("[TB] FAIL chunk_hold: got %0d reads en=%b want 4 reads en=0", aLog.size(), mem_a_rd_en); end
    I_am_ready = 4'b1000;
    @(posedge clk);
    #1 I_am_ready = '0;
    waitAllReady(30, timedOut);
    testsRun++; if (timedOut) begin testsFailed++; $display("[TB] FAIL chunk1_wait: got timeout want ycr=1111"); end
    testsRun++; if (aLog.size() != 8) begin testsFailed++; $display("[TB] FAIL chunk_count: got %0d reads want 8", aLog.size()); end
    for (int i = 0; i < 8; i++) begin
      testsRun++; if (((aLog.size() > i) ? aLog[i] : 32'hFFFF_FFFF) !== expA[i]) begin testsFailed++; $display("[TB] FAIL chunk_a_addr%0d: got %0d want %0d", i, (aLog.size() > i) ? aLog[i] : 32'hFFFF_FFFF, expA[i]); end
    end
    testsRun++; if (vLog.size() != 2 || vLog[0] !== 32'd0 || vLog[1] !== 32'd1) begin testsFailed++; $display("[TB] FAIL chunk_v_addr: got %0d reads want reads 0,1", vLog.size()); end
    for (int k = 0; k < NM; k++) begin
      testsRun++; if (laneOf(A_rows, k) !== aChunk(32'(2 * k + 1))) begin testsFailed++; $display("[TB] FAIL chunk1_A_lane%0d: got %h want %h", k, laneOf(A_rows, k), aChunk(32'(2 * k + 1))); end
      testsRun++; if (laneOf(vector_rows, k) !== vChunk(32'd1)) begin testsFailed++; $display("[TB] FAIL chunk1_V_lane%0d: got %h want %h", k, laneOf(vector_rows, k), vChunk(32'd1)); end
    end
    handshakeAll();
    @(negedge clk);
    testsRun++; if (busy !== 1'b0 || feed_done !== 1'b0) begin testsFailed++; $display("[TB] FAIL chunk_end: got busy=%b done=%b want 0/0", busy, feed_done); end
  endtask

  task automatic test_back_to_back();
    bit timedOut;
    doReset();
    total_with_additional_A = 32'd8;
    chunks_per_row = 32'd1;
    pulseRequest();
    waitAllReady(30, timedOut);
    testsRun++; if (timedOut) begin testsFailed++; $display("[TB] FAIL b2b_first_wait: got timeout want ycr=1111"); end
    pulseRequest();
    pulseRequest();
    pulseRequest();
    aLog.delete();
    handshakeAll();
    waitAllReady(30, timedOut);
    testsRun++; if (timedOut) begin testsFailed++; $display("[TB] FAIL b2b_pending_wait: got timeout want ycr=1111"); end
    testsRun++; if (aLog.size() != 4) begin testsFailed++; $display("[TB] FAIL b2b_pending_count: got %0d reads want 4", aLog.size()); end
    for (int i = 0; i < NM; i++) begin
      testsRun++; if (((aLog.size() > i) ? aLog[i] : 32'hFFFF_FFFF) !== 32'(7 - i)) begin testsFailed++; $display("[TB] FAIL b2b_a_addr%0d: got %0d want %0d", i, (aLog.size() > i) ? aLog[i] : 32'hFFFF_FFFF, 7 - i); end
    end
    testsRun++; if (laneOf(A_rows, 2) !== aChunk(32'd6)) begin testsFailed++; $display("[TB] FAIL b2b_A_lane2: got %h want %h", laneOf(A_rows, 2), aChunk(32'd6)); end
    handshakeAll();
    repeat (8) @(negedge clk);
    testsRun++; if (aLog.size() != 4 || busy !== 1'b0 || feed_done !== 1'b1) begin testsFailed++; $display("[TB] FAIL b2b_dropped: got reads=%0d busy=%b done=%b want 4/0/1", aLog.size(), busy, feed_done); end
    pulseRequest();
    repeat (8) @(negedge clk);
    testsRun++; if (aLog.size() != 4 || busy !== 1'b0 || feed_done !== 1'b1) begin testsFailed++; $display("[TB] FAIL b2b_exhausted: got reads=%0d busy=%b done=%b want 4/0/1", aLog.size(), busy, feed_done); end
  endtask

  task automatic test_abort();
    bit timedOut;
    doReset();
    total_with_additional_A = 32'd8;
    chunks_per_row = 32'd1;
    pulseRequest();
    waitAllReady(30, timedOut);
    testsRun++; if (timedOut) begin testsFailed++; $display("[TB] FAIL abort_wait: got timeout want ycr=1111"); end
    start = 1'b0;
    @(posedge clk);
    #1 start = 1'b1;
    @(negedge clk);
    testsRun++; if (you_can_read !== 4'h0 || busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL abort_clear: got ycr=%b busy=%b want 0000/0", you_can_read, busy); end
    testsRun++; if (laneOf(A_rows, 3) !== aChunk(32'd3)) begin testsFailed++; $display("[TB] FAIL abort_data_hold: got %h want %h", laneOf(A_rows, 3), aChunk(32'd3)); end
    aLog.delete();
    pulseRequest();
    waitAllReady(30, timedOut);
    testsRun++; if (timedOut || aLog.size() != 4 || aLog[0] !== 32'd3) begin testsFailed++; $display("[TB] FAIL abort_restart: got reads=%0d first=%0d want 4 reads first=3", aLog.size(), (aLog.size() > 0) ? aLog[0] : 32'hFFFF_FFFF); end
  endtask

  task automatic test_reset_mid_present();
    bit timedOut;
    I_am_ready = 4'b0011;
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    I_am_ready = '0;
    @(negedge clk);
    testsRun++; if (you_can_read !== 4'h0 || busy !== 1'b0 || A_rows !== '0) begin testsFailed++; $display("[TB] FAIL midreset_clear: got ycr=%b busy=%b A_zero=%b want 0000/0/1", you_can_read, busy, (A_rows == '0)); end
    aLog.delete();
    pulseRequest();
    waitAllReady(30, timedOut);
    testsRun++; if (timedOut || aLog.size() != 4 || aLog[0] !== 32'd3) begin testsFailed++; $display("[TB] FAIL midreset_restart: got reads=%0d first=%0d want 4 reads first=3", aLog.size(), (aLog.size() > 0) ? aLog[0] : 32'hFFFF_FFFF); end
  endtask

  initial begin
    test_reset();
    test_single_group();
    test_two_chunks();
    test_back_to_back();
    test_abort();
    test_reset_mid_present();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
